wave_table_writer: RTL and testbench

- Writer side of the waveform BRAM that the function generator reads.
- Accepts a byte stream of samples over a valid/ready handshake and writes them into one table region: SINE or TRIANGLE.
- Writes go through a registered single-port write interface (addr/data/we).
- Reports busy, a done pulse, the sample count and a running 8-bit checksum so firmware can verify each table load.

---
 rtl/wave_table_writer.sv | 127 ++++++++++++
 tb/tb_wave_table_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_table_writer.sv
// ---------------------------------------------------------------------------
// wave_table_writer
//   Writer side of the function-generator waveform BRAM. Accepts a byte
//   stream over valid/ready and writes it into one table region (SINE or
//   TRIANGLE) through a registered single-port write interface. Reports
//   busy, a done pulse, the sample count and a running 8-bit checksum so
//   firmware can verify each table load.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, region     begin a load in IDLE; region 0 = SINE, 1 = TRIANGLE
//   abort             cancel an in-progress load
//   s_valid/s_data    input sample stream, s_ready back-pressure
//   bram_addr/dout/we registered BRAM write port
//   busy, done        LOAD indicator, one-cycle completion pulse
//   aborted           sticky abort flag, cleared by the next accepted start
//   sample_count      samples written in the current or last load
//   checksum          modulo-256 sum of the samples written
// ---------------------------------------------------------------------------
module wave_table_writer #(
    parameter int                 ADDR_W    = 16,
    parameter int                 DATA_W    = 8,
    parameter logic [ADDR_W-1:0]  SINE_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0]  SINE_LAST = 16'h03FF,
    parameter logic [ADDR_W-1:0]  TRI_BASE  = 16'h0400,
    parameter logic [ADDR_W-1:0]  TRI_LAST  = 16'h0800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              region,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_dout,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] sample_count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] csum_q;
    logic              we_q;
    logic              aborted_q;
    logic              hs;

    // abort gates ready combinationally so a sample offered in the abort
    // cycle is never consumed by the writer.
    assign s_ready = (state_q == S_LOAD) && !abort;
    assign hs      = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
            count_q   <= '0;
            csum_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            // Write strobe is a single-cycle echo of the handshake.
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ptr_q     <= region ? TRI_BASE : SINE_BASE;
                        last_q    <= region ? TRI_LAST : SINE_LAST;
                        count_q   <= '0;
                        csum_q    <= '0;
                        aborted_q <= 1'b0;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (hs) begin
                        addr_q  <= ptr_q;
                        dout_q  <= s_data;
                        we_q    <= 1'b1;
                        csum_q  <= csum_q + s_data;
                        count_q <= count_q + ONE;
                        // Stop on the last address rather than wrapping.
                        if (ptr_q == last_q) state_q <= S_DONE;
                        else                 ptr_q   <= ptr_q + ONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register, so done lines up with the
    // final write strobe issued on entry to DONE.
    assign busy         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign bram_addr    = addr_q;
    assign bram_dout    = dout_q;
    assign bram_we      = we_q;
    assign aborted      = aborted_q;
    assign sample_count = count_q;
    assign checksum     = csum_q;

endmodule

// File: tb/tb_wave_table_writer.sv
module tb_wave_table_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, region, abort, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, bram_we, busy, done, aborted;
    logic [15:0] bram_addr, sample_count;
    logic [7:0]  bram_dout, checksum;

    int checks = 0;
    int errors = 0;

    wave_table_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .region(region), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .bram_we(bram_we),
        .busy(busy), .done(done), .aborted(aborted),
        .sample_count(sample_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 0; region = 0; abort = 0; s_valid = 0; s_data = 8'h00;
        #3;
        checks++;
        if ({s_ready, bram_we, busy, done, aborted, bram_addr, bram_dout, sample_count, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%h cnt=%h sum=%h busy=%b want all 0",
                     bram_we, bram_addr, sample_count, checksum, busy);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || bram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b rdy=%b we=%b want 0 0 0", busy, s_ready, bram_we);
        end
    endtask

    task automatic test_sine_full();
        int dones = 0;
        start = 1; region = 0;
        @(negedge clk);
        start = 0; s_valid = 1;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sine_enter_load got busy=%b rdy=%b want 1 1", busy, s_ready);
        end
        for (int i = 0; i < 1024; i++) begin
            s_data = i[7:0];
            @(negedge clk);
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== i[15:0] || bram_dout !== i[7:0]) begin
                errors++;
                $display("FAIL sine_write[%0d] got we=%b addr=%h d=%h want 1 %h %h",
                         i, bram_we, bram_addr, bram_dout, i[15:0], i[7:0]);
            end
            if (done === 1'b1) dones++;
            checks++;
            if (done !== (i == 1023)) begin
                errors++;
                $display("FAIL sine_done[%0d] got %b want %b", i, done, (i == 1023));
            end
        end
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sine_done_state got rdy=%b busy=%b want 0 0", s_ready, busy);
        end
        s_valid = 0;
        @(negedge clk);
        checks++;
        if (dones !== 1 || bram_we !== 1'b0 || done !== 1'b0 || sample_count !== 16'd1024 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL sine_final got dones=%0d we=%b done=%b cnt=%0d sum=%h want 1 0 0 1024 00",
                     dones, bram_we, done, sample_count, checksum);
        end
    endtask

    task automatic test_tri_full();
        int stray = 0;
        start = 1; region = 1;
        @(negedge clk);
        start = 0; region = 0; s_valid = 1; s_data = 8'h01;
        for (int i = 0; i < 1025; i++) begin
            @(negedge clk);
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== 16'h0400 + i[15:0] || bram_dout !== 8'h01 ||
                done !== (i == 1024)) begin
                errors++;
                $display("FAIL tri_write[%0d] got we=%b addr=%h d=%h done=%b want 1 %h 01 %b",
                         i, bram_we, bram_addr, bram_dout, done, 16'h0400 + i[15:0], (i == 1024));
            end
        end
        // Keep offering data past the end: nothing more may be written.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bram_we === 1'b1) stray++;
        end
        checks++;
        if (stray !== 0 || sample_count !== 16'd1025 || checksum !== 8'h01) begin
            errors++;
            $display("FAIL tri_final got stray=%0d cnt=%0d sum=%h want 0 1025 01", stray, sample_count, checksum);
        end
        s_valid = 0;
    endtask

    task automatic test_toggle_valid();
        int acc = 0;
        int cyc = 0;
        logic [7:0] sum = 8'h00;
        logic [7:0] d;
        logic v;
        start = 1; region = 0;
        @(negedge clk);
        start = 0;
        while (acc < 1024 && cyc < 4000) begin
            v = (cyc % 2 == 0);
            d = acc[7:0] ^ 8'h5A;
            s_valid = v; s_data = d;
            @(negedge clk);
            checks++;
            if (bram_we !== v || (v && (bram_addr !== acc[15:0] || bram_dout !== d)) ||
                done !== (v && acc == 1023)) begin
                errors++;
                $display("FAIL toggle_write[%0d] got we=%b addr=%h d=%h done=%b want %b %h %h %b",
                         cyc, bram_we, bram_addr, bram_dout, done, v, acc[15:0], d, (v && acc == 1023));
            end
            if (v) begin
                sum = sum + d;
                acc++;
            end
            cyc++;
        end
        s_valid = 0;
        @(negedge clk);
        checks++;
        if (acc !== 1024 || sample_count !== 16'd1024 || checksum !== sum) begin
            errors++;
            $display("FAIL toggle_final got acc=%0d cnt=%0d sum=%h want 1024 1024 %h", acc, sample_count, checksum, sum);
        end
    endtask

    task automatic test_abort();
        int writes = 0;
        int dones = 0;
        start = 1; region = 0;
        @(negedge clk);
        start = 0; s_valid = 1; s_data = 8'h05;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bram_we === 1'b1) writes++;
            if (done === 1'b1) dones++;
            checks++;
            if (bram_addr !== i[15:0]) begin
                errors++;
                $display("FAIL abort_addr[%0d] got %h want %h", i, bram_addr, i[15:0]);
            end
        end
        abort = 1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready_gate got %b want 0", s_ready);
        end
        @(negedge clk);
        abort = 0; s_valid = 0;
        if (bram_we === 1'b1) writes++;
        if (done === 1'b1) dones++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bram_we === 1'b1) writes++;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (writes !== 10 || dones !== 0 || aborted !== 1'b1 || busy !== 1'b0 ||
            sample_count !== 16'd10 || checksum !== 8'h32) begin
            errors++;
            $display("FAIL abort_final got wr=%0d dn=%0d ab=%b busy=%b cnt=%0d sum=%h want 10 0 1 0 10 32",
                     writes, dones, aborted, busy, sample_count, checksum);
        end
    endtask

    task automatic test_start_in_load();
        start = 1; region = 0;
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_aborted got %b want 0", aborted);
        end
        s_valid = 1; s_data = 8'h10;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); region = (i == 2);
            @(negedge clk);
            start = 0; region = 0;
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== i[15:0] || busy !== 1'b1) begin
                errors++;
                $display("FAIL sil_write[%0d] got we=%b addr=%h busy=%b want 1 %h 1", i, bram_we, bram_addr, busy, i[15:0]);
            end
        end
        s_valid = 0;
        checks++;
        if (sample_count !== 16'd5 || checksum !== 8'h50) begin
            errors++;
            $display("FAIL sil_count got cnt=%0d sum=%h want 5 50", sample_count, checksum);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start = 1; region = 0;
        @(negedge clk);
        start = 0; s_valid = 1; s_data = 8'h22;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, bram_we, busy, done, aborted, bram_addr, bram_dout, sample_count, checksum} !== '0) begin
            errors++;
            $display("FAIL midload_reset got rdy=%b we=%b busy=%b addr=%h cnt=%0d sum=%h want all 0",
                     s_ready, bram_we, busy, bram_addr, sample_count, checksum);
        end
        @(negedge clk);
        checks++;
        if (bram_we !== 1'b0 || busy !== 1'b0 || sample_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold got we=%b busy=%b cnt=%0d want 0 0 0", bram_we, busy, sample_count);
        end
        rst_n = 1'b1; s_valid = 0;
        @(negedge clk);
        start = 1; region = 1;
        @(negedge clk);
        start = 0; region = 0; s_valid = 1; s_data = 8'h07;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== 16'h0400 + i[15:0] || bram_dout !== 8'h07) begin
                errors++;
                $display("FAIL post_reset_write[%0d] got we=%b addr=%h d=%h want 1 %h 07",
                         i, bram_we, bram_addr, bram_dout, 16'h0400 + i[15:0]);
            end
        end
        s_valid = 0; abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if (sample_count !== 16'd3 || checksum !== 8'h15 || aborted !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_final got cnt=%0d sum=%h ab=%b want 3 15 1", sample_count, checksum, aborted);
        end
    endtask

    initial begin
        test_reset();
        test_sine_full();
        test_tri_full();
        test_toggle_valid();
        test_abort();
        test_start_in_load();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
